// File: rtl/mat_pkg.sv
// Shared definitions for the 3x3 matrix datapath (multiplier and serializer).
package mat_pkg;

    localparam int unsigned N_DEF = 3;
    localparam int unsigned W_DEF = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    typedef logic [$clog2(N_DEF)-1:0] idx_t;

    // Extract element (r,c) from a row-major packed matrix of default size.
    function automatic logic [W_DEF-1:0] elem(
        input logic [N_DEF*N_DEF*W_DEF-1:0] mat,
        input idx_t                         r,
        input idx_t                         c
    );
        return mat[(int'(r) * N_DEF + int'(c)) * W_DEF +: W_DEF];
    endfunction

endpackage

// File: rtl/mat_idx_counter.sv
// Row/column walker: row-major (col fastest) or transposed (row fastest).
module mat_idx_counter
    import mat_pkg::*;
#(
    parameter  int unsigned N  = N_DEF,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear_i,
    input  logic          advance_i,
    input  logic          transpose_i,
    output logic [IW-1:0] row_o,
    output logic [IW-1:0] col_o,
    output logic          last_o
);

    localparam logic [IW-1:0] MAX = IW'(N - 1);

    logic [IW-1:0] row_q, row_d;
    logic [IW-1:0] col_q, col_d;

    // Next index: clear wins over advance so a reload restarts at (0,0).
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear_i) begin
            row_d = '0;
            col_d = '0;
        end else if (advance_i) begin
            if (!transpose_i) begin
                if (col_q == MAX) begin
                    col_d = '0;
                    row_d = (row_q == MAX) ? '0 : row_q + IW'(1);
                end else begin
                    col_d = col_q + IW'(1);
                end
            end else begin
                if (row_q == MAX) begin
                    row_d = '0;
                    col_d = (col_q == MAX) ? '0 : col_q + IW'(1);
                end else begin
                    row_d = row_q + IW'(1);
                end
            end
        end
    end

    // Index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o  = row_q;
    assign col_o  = col_q;
    assign last_o = (row_q == MAX) && (col_q == MAX);

endmodule

// File: rtl/mat_serializer.sv
// Accepts an NxN matrix in parallel and streams it out one element per cycle.
module mat_serializer
    import mat_pkg::*;
#(
    parameter  int unsigned N  = N_DEF,
    parameter  int unsigned W  = W_DEF,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*N*W-1:0] in_mat,
    input  logic             in_transpose,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [IW-1:0]    out_row,
    output logic [IW-1:0]    out_col,
    output logic             out_last
);

    state_e             state_q, state_d;
    logic [N*N*W-1:0]   mat_q, mat_d;
    logic               mode_q, mode_d;
    logic [IW-1:0]      row, col;
    logic               idx_last;
    logic               accept;
    logic               fire;
    logic [W-1:0]       elems [N][N];

    assign accept = in_valid && in_ready;
    assign fire   = out_valid && out_ready;

    // Unpack the stored matrix so the output mux indexes by (row,col).
    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            assign elems[r][c] = mat_q[(r*N+c)*W +: W];
        end
    end

    mat_idx_counter #(.N(N)) u_idx (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (accept),
        .advance_i   (fire),
        .transpose_i (mode_q),
        .row_o       (row),
        .col_o       (col),
        .last_o      (idx_last)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a reload on the final handshake keeps streaming without a bubble.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SEND;
            SEND:    if (fire && idx_last && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: in_ready sees out_ready combinationally to allow back-to-back reloads.
    always_comb begin
        in_ready  = (state_q == IDLE) || ((state_q == SEND) && idx_last && out_ready);
        out_valid = (state_q == SEND);
        out_last  = (state_q == SEND) && idx_last;
        out_data  = elems[row][col];
        out_row   = row;
        out_col   = col;
    end

    // Matrix/mode capture only on an accepted transfer.
    always_comb begin
        mat_d  = mat_q;
        mode_d = mode_q;
        if (accept) begin
            mat_d  = in_mat;
            mode_d = in_transpose;
        end
    end

    // Payload registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mat_q  <= '0;
            mode_q <= 1'b0;
        end else begin
            mat_q  <= mat_d;
            mode_q <= mode_d;
        end
    end

endmodule

// File: doc/mat_serializer.md
# mat_serializer

Transmit-side companion to the combinational 3x3 matrix multiplier. It accepts one full N×N matrix in parallel over a valid/ready handshake. It then streams the elements out one per cycle over a second valid/ready handshake, in row-major or column-major (transposed) order. It sits between the multiplier's parallel result and the serial downstream datapath of the convolution pipeline.

## Interface
Parameters:
- N, 3: matrix dimension (rows = cols).
- W, 8: element width in bits.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_mat / in_transpose are valid.
- in_ready  out  1  block can accept a matrix this cycle.
- in_mat  in  N*N*W  packed matrix; element (r,c) at bits [(r*N+c)*W +: W].
- in_transpose  in  1  1 = emit column-major, 0 = row-major; sampled with in_mat.
- out_valid  out  1  out_data and tags are valid.
- out_ready  in  1  downstream accepts the current element.
- out_data  out  W  current element.
- out_row  out  $clog2(N)  row index of current element.
- out_col  out  $clog2(N)  column index of current element.
- out_last  out  1  current element is the final one of the matrix.

## Operation
- Two states: IDLE, SEND.
- **IDLE**
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: latch in_mat and in_transpose, clear row/col to 0, go to SEND.
- **SEND**
  - out_valid=1; out_data = stored element (out_row, out_col).
  - On out_valid&&out_ready, advance the index. Row-major: col fastest, col wraps N-1→0 and row increments. Transposed: row fastest, row wraps N-1→0 and col increments.
- **out_last** = 1 on the N*N-th element: (N-1,N-1) in both modes.
- **Last-element handshake**
  - in_ready = (state==IDLE) || (state==SEND && out_last && out_ready). This path is combinational from out_ready.
  - If a new matrix is accepted in the same cycle: load it, reset the indices, stay in SEND (no bubble).
  - Otherwise: return to IDLE.
- **Hold rule:** while out_valid && !out_ready, out_data, out_row, out_col and out_last hold stable. in_mat changes are ignored while in SEND.
- **Data path:** no arithmetic. Elements pass through bit-exact, unsigned/sign-agnostic.
- **Reset values** (rst_n low, any state including mid-stream): state=IDLE, stored matrix=0, mode=0, out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0, in_ready=1 (IDLE). A partially sent matrix is discarded.

## Timing
- Accept edge k → first element (0,0) valid in cycle k+1.
- With out_ready held high: exactly N*N cycles per matrix. Back-to-back matrices sustain 1 element/cycle with zero idle cycles.
- Each out_ready-low cycle adds one cycle of latency, with no loss or duplication of elements.
- in_ready has one combinational dependency (out_ready). All other outputs are driven from registers or from a mux over registered state.

## Structure
- Shared package mat_pkg holds:
  - the N and W defaults;
  - the state enum {IDLE, SEND};
  - the index typedef (logic [$clog2(N)-1:0]);
  - an element-extract function elem(mat, r, c).
- The multiplier and this block both import mat_pkg.
- One sub-module: mat_idx_counter. It is the row/col counter with inputs clear, advance and transpose, and outputs row, col and last.

## Test plan
Unless stated otherwise, element (r,c) = 3r+c+1 with N=3, W=8.
- **Row-major:** in_transpose=0, out_ready=1 → out_data 1,2,3,4,5,6,7,8,9 on 9 consecutive cycles starting 1 cycle after accept; out_last only on 9; then out_valid=0, in_ready=1.
- **Transposed:** in_transpose=1 → 1,4,7,2,5,8,3,6,9; (out_row,out_col) (0,0),(1,0),(2,0),(0,1)…; out_last on 9.
- **Backpressure:** drop out_ready for 3 cycles while element 5 is presented → out_data=5, out_row=1, out_col=1 held for 4 cycles; then the sequence resumes at 6; total 12 cycles.
- **Back-to-back:** a second matrix with elements 10..18 is held valid → in_ready pulses during element 9's handshake; 10 appears the next cycle; 18 elements in 18 consecutive cycles.
- **Reset mid-stream:** assert rst_n low after 4 elements have been sent → out_valid=0, out_data=0, in_ready=1 immediately. The next matrix streams from (0,0) with value 1.
- **Input ignored in SEND:** toggle in_mat and in_transpose during SEND with in_valid=1 → the current stream is unchanged and in_ready=0 until the last handshake.
